// File: rtl/uart_cmd_bridge_if.sv
// uart_cmd_bridge_if: byte stream, response and memory-controller signals of the command bridge
interface uart_cmd_bridge_if #(
  parameter int DW = 32
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          rd_req;
  logic          wr_req;
  logic [31:0]   addr;
  logic [DW-1:0] wr_d;
  logic [3:0]    wr_byte_en;
  logic [5:0]    rd_num_dwords;
  logic [DW-1:0] rd_d;
  logic          rd_rdy;
  logic          busy;
  logic [2:0]    err_flags;
  modport master (
    input  rx_valid, rx_data, tx_ready, rd_d, rd_rdy, busy,
    output tx_start, tx_data, rd_req, wr_req, addr, wr_d, wr_byte_en, rd_num_dwords, err_flags
  );
  modport slave (
    output rx_valid, rx_data, tx_ready, rd_d, rd_rdy, busy,
    input  tx_start, tx_data, rd_req, wr_req, addr, wr_d, wr_byte_en, rd_num_dwords, err_flags
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: decodes UART command frames into memory requests and serialises word responses
module uart_cmd_bridge #(
  parameter int          DATA_BYTES     = 4,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd120000,
  parameter logic [31:0] CONST_VAL      = 32'd259
) (
  input logic clk,
  input logic reset,
  uart_cmd_bridge_if.master bus
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT_MEM, SEND} state_t;
  state_t r_state, w_next;
  logic [3:0]    r_fcnt, r_bidx;
  logic [7:0]    r_cmd, r_op, r_tx_data;
  logic [DW-1:0] r_payload, r_resp, r_sh, r_cnt, r_rd_word, r_wr_d;
  logic [DW-1:0] r_fifo [FIFO_DEPTH];
  logic [23:0]   r_idle;
  logic [31:0]   r_addr;
  logic [6:0]    r_n, r_rcv, r_words;
  logic [5:0]    r_rd_num;
  logic [2:0]    r_err;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_fill;
  logic          r_req_done, r_busy_seen, r_wait_low, r_tx_start, r_rd_req, r_wr_req;
  logic [DW-1:0] w_resp, w_word, w_sel;
  logic [6:0]    w_n;
  logic          w_last_byte, w_timeout, w_drop, w_is_wr, w_is_burst, w_fire, w_rd_in;
  logic          w_push, w_ovf, w_pop, w_mem_done, w_tx_fire;
  assign w_last_byte = bus.rx_valid && r_fcnt == 4'(DATA_BYTES);
  assign w_timeout   = !bus.rx_valid && r_fcnt != 4'd0 && r_idle == TIMEOUT_CYCLES - 24'd1;
  assign w_drop      = w_last_byte && r_state != IDLE;
  assign w_n = r_payload[5:0] == 6'd0 ? 7'd1
             : {1'b0, r_payload[5:0]} > 7'(FIFO_DEPTH) ? 7'(FIFO_DEPTH) : {1'b0, r_payload[5:0]};
  assign w_resp = (r_cmd == 8'h01 || r_cmd == 8'h02) ? r_payload
                : r_cmd == 8'h03 ? DW'(8'h03)
                : r_cmd == 8'h04 ? r_rd_word
                : r_cmd == 8'h05 ? DW'(8'h05)
                : r_cmd == 8'h07 ? DW'(CONST_VAL)
                : r_cmd == 8'h09 ? DW'({r_fill, r_err})
                : r_cnt;
  assign w_is_wr    = r_op == 8'h03;
  assign w_is_burst = r_op == 8'h08;
  assign w_fire     = r_state == WAIT_MEM && !r_req_done && !bus.busy;
  assign w_rd_in    = r_state == WAIT_MEM && r_req_done && !w_is_wr && bus.rd_rdy;
  assign w_push     = w_rd_in && w_is_burst && r_fill != (AW+1)'(FIFO_DEPTH);
  assign w_ovf      = w_rd_in && w_is_burst && r_fill == (AW+1)'(FIFO_DEPTH);
  assign w_mem_done = w_is_wr ? r_busy_seen && !bus.busy : w_rd_in && r_rcv == r_n - 7'd1;
  assign w_tx_fire  = r_state == SEND && r_words != 7'd0 && bus.tx_ready && !r_wait_low;
  assign w_pop      = w_tx_fire && r_bidx == 4'd0 && w_is_burst && r_fill != '0;
  assign w_word     = w_is_burst ? r_fifo[r_rp] : r_resp;
  assign w_sel      = r_bidx == 4'd0 ? w_word : r_sh;
  assign bus.tx_start      = r_tx_start;
  assign bus.tx_data       = r_tx_data;
  assign bus.rd_req        = r_rd_req;
  assign bus.wr_req        = r_wr_req;
  assign bus.addr          = r_addr;
  assign bus.wr_d          = r_wr_d;
  assign bus.wr_byte_en    = 4'hF;
  assign bus.rd_num_dwords = r_rd_num;
  assign bus.err_flags     = r_err;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state: memory commands detour through WAIT_MEM, leave SEND once the last byte is taken
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = w_last_byte ? EXEC : IDLE;
      EXEC:     w_next = (r_cmd == 8'h03 || r_cmd == 8'h05 || r_cmd == 8'h08) ? WAIT_MEM : SEND;
      WAIT_MEM: w_next = w_mem_done ? SEND : WAIT_MEM;
      SEND:     w_next = (r_words == 7'd0 && r_wait_low && !bus.tx_ready) ? IDLE : SEND;
      default:  w_next = IDLE;
    endcase
  end
  // frame assembly; bytes keep assembling in every state and a stalled partial frame is discarded
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_fcnt    <= '0;
      r_cmd     <= '0;
      r_payload <= '0;
      r_idle    <= '0;
    end else begin
      r_idle <= (bus.rx_valid || r_fcnt == 4'd0 || w_timeout) ? 24'd0 : r_idle + 24'd1;
      if (w_timeout) r_fcnt <= '0;
      else if (bus.rx_valid) begin
        r_fcnt <= w_last_byte ? 4'd0 : r_fcnt + 4'd1;
        if (r_fcnt == 4'd0) r_cmd <= bus.rx_data;
        else r_payload <= (r_payload << 8) | DW'(bus.rx_data);
      end
    end
  // command execution, single-shot memory requests and read-word capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_op        <= '0;
      r_resp      <= '0;
      r_cnt       <= '0;
      r_rd_word   <= '0;
      r_n         <= 7'd1;
      r_rcv       <= '0;
      r_words     <= '0;
      r_req_done  <= 1'b0;
      r_busy_seen <= 1'b0;
      r_rd_req    <= 1'b0;
      r_wr_req    <= 1'b0;
      r_addr      <= '0;
      r_wr_d      <= '0;
      r_rd_num    <= 6'd1;
    end else begin
      r_rd_req <= w_fire && !w_is_wr;
      r_wr_req <= w_fire && w_is_wr;
      if (bus.rd_rdy) r_rd_word <= bus.rd_d;
      if (r_state == EXEC) begin
        r_op        <= r_cmd;
        r_resp      <= w_resp;
        r_req_done  <= 1'b0;
        r_busy_seen <= 1'b0;
        r_rcv       <= '0;
        r_n         <= r_cmd == 8'h08 ? w_n : 7'd1;
        r_words     <= r_cmd == 8'h08 ? w_n : 7'd1;
        if (r_cmd == 8'h01) r_addr <= 32'(r_payload);
        if (r_cmd == 8'h02) r_wr_d <= r_payload;
        if (r_cmd == 8'h05 || r_cmd == 8'h08) r_rd_num <= r_cmd == 8'h08 ? w_n[5:0] : 6'd1;
        if (r_cmd == 8'h06) r_cnt <= r_cnt + 1'b1;
      end else begin
        if (w_fire) r_req_done <= 1'b1;
        if (r_req_done && bus.busy) r_busy_seen <= 1'b1;
        if (w_rd_in) r_rcv <= r_rcv + 7'd1;
        if (w_tx_fire && r_bidx == 4'(DATA_BYTES - 1)) r_words <= r_words - 7'd1;
      end
    end
  // byte serialiser: one strobe per byte, re-armed only after tx_ready dips low
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_sh       <= '0;
      r_bidx     <= '0;
      r_wait_low <= 1'b0;
    end else begin
      r_tx_start <= w_tx_fire;
      if (w_tx_fire) begin
        r_wait_low <= 1'b1;
        r_tx_data  <= w_sel[DW-1 -: 8];
        r_sh       <= w_sel << 8;
        r_bidx     <= r_bidx == 4'(DATA_BYTES - 1) ? 4'd0 : r_bidx + 4'd1;
      end else if (!bus.tx_ready) r_wait_low <= 1'b0;
    end
  // burst FIFO pointers and fill level
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_fill <= r_fill + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // burst FIFO storage
  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wp] <= bus.rd_d;
  // sticky error flags; a STATUS command clears what it reports
  always_ff @(posedge clk or posedge reset)
    if (reset) r_err <= '0;
    else r_err <= (r_state == EXEC && r_cmd == 8'h09 ? 3'd0 : r_err) | {w_ovf, w_drop, w_timeout};
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: directed and randomized command frames checked against a word-level model
module tb_uart_cmd_bridge;
  localparam int T = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uart_cmd_bridge_if #(.DW(32)) bus ();
  uart_cmd_bridge #(.DATA_BYTES(4), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(24'(T)), .CONST_VAL(32'd259))
    dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] rd_src[$];
  logic [31:0] exp_q[$];
  int n_tx = 0, tx_busy = 0, rd_left = 0, rd_dly = 0, busy_cnt = 0, wr_cnt = 0;
  logic m_rd_rdy = 1'b0, busy_hold = 1'b0;
  logic [31:0] m_rd_d = '0, wr_addr_cap = '0, wr_d_cap = '0;
  logic [31:0] m_addr = '0, m_wrd = '0, m_cnt = '0, m_last = '0;
  logic [2:0]  m_err = '0;
  assign bus.tx_ready = (tx_busy == 0);
  assign bus.rd_rdy   = m_rd_rdy;
  assign bus.rd_d     = m_rd_d;
  assign bus.busy     = busy_hold || busy_cnt != 0;
  // UART transmitter: captures each strobed byte, then stays busy a few clocks
  always @(posedge clk) begin
    if (bus.tx_start) begin
      tx_q.push_back(bus.tx_data);
      n_tx <= n_tx + 1;
      tx_busy <= 3 + int'($urandom_range(0, 3));
    end else if (tx_busy > 0) tx_busy <= tx_busy - 1;
  end
  // memory controller: busy pulse after each write, words from rd_src after each read request
  always @(posedge clk) begin
    m_rd_rdy <= 1'b0;
    if (bus.wr_req) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr_cap <= bus.addr;
      wr_d_cap <= bus.wr_d;
      busy_cnt <= 1 + int'($urandom_range(0, 4));
    end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (bus.rd_req) begin
      rd_left <= int'(bus.rd_num_dwords);
      rd_dly <= 2;
    end else if (rd_dly > 0) rd_dly <= rd_dly - 1;
    else if (rd_left > 0) begin
      m_rd_rdy <= 1'b1;
      m_rd_d <= rd_src.pop_front();
      rd_left <= rd_left - 1;
    end
  end
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int gmax);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(0, gmax)) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] c, input logic [31:0] p, input int gmax);
    logic [39:0] f;
    f = {c, p};
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8], gmax);
  endtask
  // expected response words from the command semantics
  task automatic predict(input logic [7:0] c, input logic [31:0] p);
    int n;
    exp_q.delete();
    case (c)
      8'h01: begin m_addr = p; exp_q.push_back(p); end
      8'h02: begin m_wrd = p; exp_q.push_back(p); end
      8'h03: exp_q.push_back(32'd3);
      8'h04: exp_q.push_back(m_last);
      8'h05: begin m_last = $urandom; rd_src.push_back(m_last); exp_q.push_back(32'd5); end
      8'h06: begin exp_q.push_back(m_cnt); m_cnt = m_cnt + 1; end
      8'h07: exp_q.push_back(32'd259);
      8'h08: begin
        n = int'(p % 64);
        if (n == 0) n = 1;
        if (n > 16) n = 16;
        for (int i = 0; i < n; i++) begin
          m_last = $urandom;
          rd_src.push_back(m_last);
          exp_q.push_back(m_last);
        end
      end
      8'h09: begin exp_q.push_back({29'd0, m_err}); m_err = 3'd0; end
      default: exp_q.push_back(m_cnt);
    endcase
  endtask
  task automatic get_words(input string tag);
    logic [31:0] w;
    int t;
    t = 0;
    while (tx_q.size() < 4 * exp_q.size() && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_len"}, 64'(tx_q.size()), 64'(4 * exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      w = '0;
      for (int j = 0; j < 4; j++) w = {w[23:0], tx_q.pop_front()};
      check($sformatf("%s_w%0d", tag, i), w, exp_q[i]);
    end
    repeat (10) @(negedge clk);
  endtask
  task automatic run(input logic [7:0] c, input logic [31:0] p, input string tag);
    predict(c, p);
    send_frame(c, p, 2);
    get_words(tag);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_rd_num", bus.rd_num_dwords, 1);
    check("rst_err", bus.err_flags, 0);
    check("rst_addr", bus.addr, 0);
    @(negedge clk);
    reset = 1'b0;
    tx_q.delete();
    m_cnt = '0; m_err = '0; m_last = '0; m_addr = '0; m_wrd = '0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int base, t;
    logic [7:0] c;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_rd_req", bus.rd_req, 0);
    check("rst_wr_req", bus.wr_req, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wr_d", bus.wr_d, 0);
    check("rst_rd_num", bus.rd_num_dwords, 1);
    check("rst_err", bus.err_flags, 0);
    check("byte_en", bus.wr_byte_en, 4'hF);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run(8'h01, 32'h10, "addr");
    run(8'h02, 32'hDEADBEEF, "load");
    check("addr_out", bus.addr, 32'h10);
    check("wr_d_out", bus.wr_d, 32'hDEADBEEF);
    busy_hold = 1'b1;
    predict(8'h03, 32'h0);
    send_frame(8'h03, 32'h0, 2);
    repeat (20) @(negedge clk);
    check("wr_held_busy", wr_cnt, 0);
    busy_hold = 1'b0;
    get_words("write");
    check("wr_pulses", wr_cnt, 1);
    check("wr_addr", wr_addr_cap, 32'h10);
    check("wr_data", wr_d_cap, 32'hDEADBEEF);
    base = n_tx;
    predict(8'h05, 32'h0);
    void'(rd_src.pop_back());
    rd_src.push_back(32'hCAFEF00D);
    m_last = 32'hCAFEF00D;
    send_frame(8'h05, 32'h0, 2);
    get_words("read_req");
    check("rd_num_single", bus.rd_num_dwords, 1);
    run(8'h04, 32'h0, "read");
    check("tx_pulses", n_tx - base, 8);
    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      rd_src.push_back(32'(i));
      exp_q.push_back(32'(i));
    end
    m_last = 32'd4;
    send_frame(8'h08, 32'd4, 2);
    get_words("burst4");
    check("burst4_num", bus.rd_num_dwords, 4);
    check("burst4_err", bus.err_flags, 0);
    run(8'h08, 32'd40, "burst40");
    check("burst40_num", bus.rd_num_dwords, 16);
    send_byte(8'h07, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    repeat (T + 5) @(negedge clk);
    check("timeout_flag", bus.err_flags, 3'b001);
    m_err = m_err | 3'b001;
    run(8'h07, 32'h0, "const");
    run(8'h09, 32'h0, "status_to");
    check("status_clear", bus.err_flags, 0);
    predict(8'h06, 32'h0);
    send_frame(8'h06, 32'h0, 0);
    send_frame(8'h07, 32'h0, 0);
    m_err = m_err | 3'b010;
    get_words("count_drop");
    run(8'h09, 32'h0, "status_drop");
    for (int k = 0; k < 24; k++) begin
      c = 8'($urandom_range(0, 10));
      if (c == 8'h00) c = 8'hA5;
      run(c, $urandom, $sformatf("rnd%0d_c%02h", k, c));
    end
    do_reset();
    run(8'h06, 32'h0, "count0");
    send_frame(8'h06, 32'h0, 2);
    t = 0;
    while (tx_q.size() < 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("partial_len", 64'(tx_q.size()), 2);
    check("partial_b0", tx_q[0], 8'h00);
    check("partial_b1", tx_q[1], 8'h00);
    do_reset();
    run(8'h06, 32'h0, "count_after_rst");
    send_byte(8'h06, 1);
    send_byte(8'h00, 1);
    do_reset();
    run(8'h07, 32'h0, "const_after_rst");
    repeat (30) @(negedge clk);
    check("no_extra_bytes", 64'(tx_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
